// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared word widths, reset address and fetch-entry type for the
//               instruction fetch front end.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int WORD_W      = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
        return pc + WORD_W'(INSTR_BYTES);
    endfunction

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] pc);
        return pc & ~(WORD_W'(INSTR_BYTES - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Prefetch buffer of {pc, instr} entries with one-cycle flush.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           push_data,
    output fetch_entry_t           head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    fetch_entry_t   r_mem [DEPTH];

    logic w_full;
    logic w_push_en;
    logic w_pop_en;

    // Pointers carry one extra wrap bit so the difference is the occupancy.
    assign count     = r_wr_ptr - r_rd_ptr;
    assign empty     = (count == '0);
    assign w_full    = (count == (PTR_W + 1)'(DEPTH));
    assign w_push_en = push && !w_full;
    assign w_pop_en  = pop && !empty;
    assign head      = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_en) begin
                r_mem[r_wr_ptr[PTR_W-1:0]] <= push_data;
                r_wr_ptr                   <= r_wr_ptr + 1'b1;
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && w_full));

endmodule
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : Fetch PC, imem request issue and prefetch buffering with
//               redirect flush, feeding the datapath over valid/ready.
// Revision    : 1.0  initial release
// ============================================================================
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clka,
    input  logic              rst,
    output logic              imem_en,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_instr,
    output logic [WORD_W-1:0] out_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WORD_W-1:0] r_fetch_pc;
    logic [WORD_W-1:0] r_inflight_pc;
    logic              r_inflight;

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_occupancy;
    logic              w_empty;
    logic              w_issue;
    logic              w_kill;
    logic              w_push;
    logic              w_pop;
    fetch_entry_t      w_push_data;
    fetch_entry_t      w_head;

    // Reserve a slot for every outstanding read so a return can always be pushed.
    assign w_occupancy = w_count + CNT_W'(r_inflight);
    assign w_issue     = !rst && !redirect && (w_occupancy < CNT_W'(DEPTH));
    assign w_kill      = redirect;
    assign w_push      = r_inflight && !w_kill;
    assign w_pop       = out_ready && !w_empty;
    assign w_push_data = '{pc: r_inflight_pc, instr: imem_rdata};

    assign imem_en   = w_issue;
    assign imem_addr = r_fetch_pc;
    assign out_valid = !w_empty;
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;

    always_ff @(posedge clka) begin
        if (rst) begin
            r_fetch_pc    <= word_align(RESET_PC);
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (redirect) begin
                r_fetch_pc <= word_align(redirect_pc);
            end else if (w_issue) begin
                r_fetch_pc    <= next_pc(r_fetch_pc);
                r_inflight_pc <= r_fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk       (clka),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .flush     (redirect),
        .push_data (w_push_data),
        .head      (w_head),
        .empty     (w_empty),
        .count     (w_count)
    );

    a_occupancy_bound: assert property (@(posedge clka) disable iff (rst)
        w_occupancy <= CNT_W'(DEPTH));

endmodule
`default_nettype wire
